// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Source encoding and the round-robin helper live here.
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e rr_next(input src_e granted);
        return (granted == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard with set/clear/flush and stall detection.
// Stalls look only at registered state; a same-cycle clear is not bypassed.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREG = regfile_wb_arbiter_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 set_valid,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_valid,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [NREG-1:0]      pending,
    output logic                 hazard_stall,
    output logic                 waw_stall
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_src_mask;
    logic [NREG-1:0] w_next;

    // Bit 0 is never produced, which keeps x0 permanently clear.
    function automatic logic [NREG-1:0] onehot(
        input logic [REG_IDX_W-1:0] idx
    );
        logic [NREG-1:0] m;
        m = '0;
        for (int i = 1; i < NREG; i++) begin
            if (idx == REG_IDX_W'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign w_set_mask = set_valid ? onehot(set_idx) : '0;
    assign w_clr_mask = clr_valid ? onehot(clr_idx) : '0;
    assign w_src_mask = onehot(rs1) | onehot(rs2);

    assign w_next = flush ? '0
                  : ((r_pending & ~w_clr_mask) | w_set_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign pending      = r_pending;
    assign hazard_stall = |(r_pending & w_src_mask);
    assign waw_stall    = |(r_pending & w_set_mask);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs load unit) feeding a registered
// register-file write port, plus the in-flight destination scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = regfile_wb_arbiter_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    output logic                 mem_ready,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 hazard_stall,
    output logic                 waw_stall,
    input  logic                 flush,
    output logic [NREG-1:0]      pending
);

    src_e                 r_ptr;
    logic                 r_rf_we;
    logic [REG_IDX_W-1:0] r_rf_rd;
    logic [XLEN-1:0]      r_rf_wdata;

    logic                 w_both;
    logic                 w_alu_hs;
    logic                 w_mem_hs;
    logic                 w_hs;
    logic [REG_IDX_W-1:0] w_rd;
    logic [XLEN-1:0]      w_data;

    assign w_both = alu_valid && mem_valid;

    // The pointer only breaks ties; a lone requester is always granted.
    assign alu_ready = !reset && alu_valid
                    && (!mem_valid || (r_ptr == SRC_ALU));
    assign mem_ready = !reset && mem_valid
                    && (!alu_valid || (r_ptr == SRC_MEM));

    assign w_alu_hs = alu_valid && alu_ready;
    assign w_mem_hs = mem_valid && mem_ready;
    assign w_hs     = w_alu_hs || w_mem_hs;
    assign w_rd     = w_mem_hs ? mem_rd   : alu_rd;
    assign w_data   = w_mem_hs ? mem_data : alu_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= SRC_ALU;
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_hs && (w_rd != '0);
            if (w_hs) begin
                r_rf_rd    <= w_rd;
                r_rf_wdata <= w_data;
            end
            if (w_hs && w_both) begin
                r_ptr <= rr_next(w_mem_hs ? SRC_MEM : SRC_ALU);
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .set_valid    (issue_valid),
        .set_idx      (issue_rd),
        .clr_valid    (w_hs),
        .clr_idx      (w_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .pending      (pending),
        .hazard_stall (hazard_stall),
        .waw_stall    (waw_stall)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, writeback timing,
// scoreboard set/clear/flush and reset behaviour.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            hazard_stall;
    logic            waw_stall;
    logic            flush;
    logic [NREG-1:0] pending;

    int vec;
    int errs;

    regfile_wb_arbiter #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .hazard_stall (hazard_stall),
        .waw_stall    (waw_stall),
        .flush        (flush),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        alu_rd = 5'd1;
        mem_rd = 5'd2;
        #1;
        vec++;
        if (alu_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_alu_ready: got %b want 0", alu_ready);
        end
        vec++;
        if (mem_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_mem_ready: got %b want 0", mem_ready);
        end
        tick();
        vec++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 64'd0) begin
            errs++;
            $display("FAIL reset_wb: got we=%b rd=%0d d=%0h want 0/0/0",
                     rf_we, rf_rd, rf_wdata);
        end
        vec++;
        if (pending !== 32'd0) begin
            errs++;
            $display("FAIL reset_pending: got %h want 0", pending);
        end
        idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rr();
        logic exp_a;
        logic [4:0] exp_rd;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 64'h111;
        mem_valid = 1'b1;
        mem_rd    = 5'd4;
        mem_data  = 64'h222;
        for (int k = 0; k < 4; k++) begin
            exp_a  = ((k % 2) == 0);
            exp_rd = exp_a ? 5'd3 : 5'd4;
            #1;
            vec++;
            if (alu_ready !== exp_a || mem_ready !== !exp_a) begin
                errs++;
                $display("FAIL rr_grant[%0d]: got a=%b m=%b want a=%b m=%b",
                         k, alu_ready, mem_ready, exp_a, !exp_a);
            end
            tick();
            vec++;
            if (rf_we !== 1'b1 || rf_rd !== exp_rd) begin
                errs++;
                $display("FAIL rr_wb[%0d]: got we=%b rd=%0d want 1/%0d",
                         k, rf_we, rf_rd, exp_rd);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_single();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 64'hAA;
        #1;
        vec++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            errs++;
            $display("FAIL single_ready: got a=%b m=%b want 1/0",
                     alu_ready, mem_ready);
        end
        tick();
        idle();
        vec++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 64'hAA) begin
            errs++;
            $display("FAIL single_wb: got we=%b rd=%0d d=%0h want 1/5/aa",
                     rf_we, rf_rd, rf_wdata);
        end
        tick();
        vec++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 64'hAA) begin
            errs++;
            $display("FAIL single_hold: got we=%b rd=%0d d=%0h want 0/5/aa",
                     rf_we, rf_rd, rf_wdata);
        end
    endtask

    task automatic test_mem_only();
        mem_valid = 1'b1;
        mem_rd    = 5'd17;
        mem_data  = 64'hDEAD_BEEF_0000_0001;
        #1;
        vec++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errs++;
            $display("FAIL mem_ready: got a=%b m=%b want 0/1",
                     alu_ready, mem_ready);
        end
        tick();
        idle();
        vec++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd17
            || rf_wdata !== 64'hDEAD_BEEF_0000_0001) begin
            errs++;
            $display("FAIL mem_wb: got we=%b rd=%0d d=%0h want 1/17/deadbeef00000001",
                     rf_we, rf_rd, rf_wdata);
        end
        tick();
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        vec++;
        if (hazard_stall !== 1'b1 || pending !== 32'h0000_0080) begin
            errs++;
            $display("FAIL hazard_set: got hz=%b p=%h want 1/00000080",
                     hazard_stall, pending);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 64'h1234;
        #1;
        vec++;
        if (mem_ready !== 1'b1 || hazard_stall !== 1'b1) begin
            errs++;
            $display("FAIL hazard_nobypass: got rdy=%b hz=%b want 1/1",
                     mem_ready, hazard_stall);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        vec++;
        if (pending !== 32'd0 || hazard_stall !== 1'b0) begin
            errs++;
            $display("FAIL hazard_clear: got p=%h hz=%b want 0/0",
                     pending, hazard_stall);
        end
        vec++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 64'h1234) begin
            errs++;
            $display("FAIL hazard_wb: got we=%b rd=%0d d=%0h want 1/7/1234",
                     rf_we, rf_rd, rf_wdata);
        end
        rs1 = 5'd0;
        rs2 = 5'd0;
        idle();
        tick();
    endtask

    task automatic test_waw();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        vec++;
        if (waw_stall !== 1'b0) begin
            errs++;
            $display("FAIL waw_first: got %b want 0", waw_stall);
        end
        tick();
        rs2 = 5'd7;
        #1;
        vec++;
        if (waw_stall !== 1'b1 || hazard_stall !== 1'b1) begin
            errs++;
            $display("FAIL waw_again: got waw=%b hz=%b want 1/1",
                     waw_stall, hazard_stall);
        end
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'h0000_0080) begin
            errs++;
            $display("FAIL waw_pending: got %h want 00000080", pending);
        end
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'd0) begin
            errs++;
            $display("FAIL waw_clear: got %h want 0", pending);
        end
    endtask

    task automatic test_set_clr();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        alu_valid   = 1'b1;
        alu_rd      = 5'd9;
        alu_data    = 64'h99;
        tick();
        #1;
        vec++;
        if (pending !== 32'h0000_0200) begin
            errs++;
            $display("FAIL setwins: got %h want 00000200", pending);
        end
        issue_rd = 5'd10;
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'h0000_0400) begin
            errs++;
            $display("FAIL set_and_clr: got %h want 00000400", pending);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd10;
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'd0) begin
            errs++;
            $display("FAIL set_clr_drain: got %h want 0", pending);
        end
    endtask

    task automatic test_rd0();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 64'h55;
        #1;
        vec++;
        if (alu_ready !== 1'b1) begin
            errs++;
            $display("FAIL rd0_ready: got %b want 1", alu_ready);
        end
        tick();
        idle();
        vec++;
        if (rf_we !== 1'b0) begin
            errs++;
            $display("FAIL rd0_we: got %b want 0", rf_we);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'd0 || waw_stall !== 1'b0) begin
            errs++;
            $display("FAIL rd0_issue: got p=%h waw=%b want 0/0",
                     pending, waw_stall);
        end
    endtask

    task automatic test_flush();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_rd = 5'd7;
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'h0000_0088) begin
            errs++;
            $display("FAIL flush_pre: got %h want 00000088", pending);
        end
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        mem_valid   = 1'b1;
        mem_rd      = 5'd20;
        mem_data    = 64'h77;
        #1;
        vec++;
        if (waw_stall !== 1'b0 || mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_cycle: got waw=%b rdy=%b want 0/1",
                     waw_stall, mem_ready);
        end
        tick();
        idle();
        #1;
        vec++;
        if (pending !== 32'd0) begin
            errs++;
            $display("FAIL flush_pending: got %h want 0", pending);
        end
        vec++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd20 || rf_wdata !== 64'h77) begin
            errs++;
            $display("FAIL flush_wb: got we=%b rd=%0d d=%0h want 1/20/77",
                     rf_we, rf_rd, rf_wdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1;
        alu_rd    = 5'd6;
        alu_data  = 64'h66;
        tick();
        reset       = 1'b1;
        mem_valid   = 1'b1;
        mem_rd      = 5'd8;
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        #1;
        vec++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_ready: got a=%b m=%b want 0/0",
                     alu_ready, mem_ready);
        end
        vec++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd6) begin
            errs++;
            $display("FAIL rstmid_prewb: got we=%b rd=%0d want 1/6",
                     rf_we, rf_rd);
        end
        tick();
        vec++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || pending !== 32'd0) begin
            errs++;
            $display("FAIL rstmid_after: got we=%b rd=%0d p=%h want 0/0/0",
                     rf_we, rf_rd, pending);
        end
        idle();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_rr();
        test_single();
        test_mem_only();
        test_hazard();
        test_waw();
        test_set_clr();
        test_rd0();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 64, data width of the register-file write port.
REQ-002 Parameter: NREG, default 32, number of architectural registers; register index width is 5.
REQ-003 Port: clk  input  1  clock; reset  input  1  reset (synchronous, active-high).
REQ-004 Ports: alu_valid  input  1; alu_rd  input  5; alu_data  input  XLEN; alu_ready  output  1. These form the ALU writeback request.
REQ-005 Ports: mem_valid  input  1; mem_rd  input  5; mem_data  input  XLEN; mem_ready  output  1. These form the load-unit writeback request.
REQ-006 Ports: rf_we  output  1; rf_rd  output  5; rf_wdata  output  XLEN. These drive the register-file write port (RegWrite/RD/WriteData).
REQ-007 Ports: issue_valid  input  1; issue_rd  input  5. These mark a new in-flight destination.
REQ-008 Ports: rs1, rs2  input  5 each; these are decode-stage source indices.
REQ-009 Ports: hazard_stall  output  1 (source hazard); waw_stall  output  1 (destination already pending).
REQ-010 Port: flush  input  1; clears all pending tracking.
REQ-011 Port: pending  output  NREG; exposes the scoreboard for debug.

Function
REQ-012 The block shall complete a handshake on a source when that source's valid and ready are both 1 on a rising clk edge.
REQ-013 The block shall drive ready combinationally; it shall assert ready to at most one source per cycle.
REQ-014 If only one source is valid, the block shall assert ready to that source.
REQ-015 If both sources are valid, the block shall assert ready to the source not granted at the last contended handshake (round-robin); the pointer shall favour ALU after reset.
REQ-016 The block shall update the round-robin pointer only on a handshake that occurs while both sources are valid.
REQ-017 Writeback latency shall be 1 cycle: rf_we, rf_rd and rf_wdata shall be registered and present the accepted request in the cycle after the handshake.
REQ-018 A handshake with rd=0 shall be accepted (ready=1) but shall produce rf_we=0 the next cycle.
REQ-019 rf_we shall be 0 in any cycle following a cycle with no handshake; rf_rd and rf_wdata shall then hold their previous values.
REQ-020 A set operation shall occur when issue_valid=1 and issue_rd!=0; it shall set pending[issue_rd] at the clock edge.
REQ-021 A handshake with rd!=0 shall clear pending[rd] at the handshake edge.
REQ-022 If a set and a clear target the same index in the same cycle, the set shall win.
REQ-023 Set and clear operations on different indices in the same cycle shall both take effect.
REQ-024 pending[0] shall always be 0.
REQ-025 hazard_stall shall be 1 if (rs1!=0 and pending[rs1]) or (rs2!=0 and pending[rs2]). It shall use registered pending only, with no same-cycle bypass of a clear.
REQ-026 waw_stall shall be 1 when issue_valid=1, issue_rd!=0 and pending[issue_rd]=1. The block shall still perform the set in that case; it is the issuer's duty to hold issue.
REQ-027 flush=1 shall clear all pending bits at the edge. A same-cycle set shall be discarded. A same-cycle handshake shall still perform its write.

Reset
REQ-028 While reset=1 at a clk edge, the block shall set pending to all zeros, rf_we=0, rf_rd=0, rf_wdata=0, and the pointer to ALU.
REQ-029 While reset=1, alu_ready and mem_ready shall be 0, and no handshake shall occur.
REQ-030 Reset asserted in the cycle after a handshake shall force rf_we=0 at the reset edge; that write shall be lost.

Structure
REQ-031 A shared package shall hold the constants REG_IDX_W=5, NREG=32 and the source encoding (SRC_ALU=0, SRC_MEM=1).
REQ-032 The scoreboard (pending vector, set/clear/flush logic, stall comparators) shall be one sub-module, regfile_scoreboard; the arbiter and writeback register shall stay in the top module.

Verification
REQ-033 Scenario: alu_valid only, rd=5, data=0xAA. Required response: alu_ready=1 the same cycle; the next cycle rf_we=1, rf_rd=5, rf_wdata=0xAA.
REQ-034 Scenario: both sources valid for 4 cycles after reset (alu rd=3, mem rd=4). Required response: grants in order ALU, MEM, ALU, MEM; rf_rd sequence 3,4,3,4, each one cycle after its grant.
REQ-035 Scenario: issue rd=7, then rs1=7. Required response: hazard_stall=1. Then mem writeback to rd=7 is accepted; the next cycle pending[7]=0 and hazard_stall=0.
REQ-036 Scenario: issue_rd=9 while an ALU handshake to rd=9 occurs in the same cycle. Required response: pending[9]=1 after the edge.
REQ-037 Scenario: ALU writeback rd=0, data=0x55. Required response: alu_ready=1 and rf_we=0 the next cycle. Scenario: issue_rd=0. Required response: pending stays all zeros.
REQ-038 Scenario: pending={3,7}, then flush=1 with issue_rd=12. Required response: pending=0 after the edge, waw_stall=0. Scenario: reset asserted mid-stream. Required response: rf_we=0 and both ready signals=0.
